// File: rtl/sw_score_controller_pkg.sv
// Shared definitions for the Smith-Waterman scoring job controller:
// base encodings, biased zero score, state and result-error encodings,
// and the bit-count helper used to size query-length fields.
package sw_score_controller_pkg;

   // Default geometry of the scoring array this controller drives.
   localparam int DEF_SCORE_WIDTH = 12;
   localparam int DEF_LENGTH      = 128;
   localparam int DEF_TGT_WIDTH   = 16;

   // Nucleotide encodings shared with the array.
   localparam logic [1:0] BASE_A = 2'b10;
   localparam logic [1:0] BASE_G = 2'b11;
   localparam logic [1:0] BASE_T = 2'b00;
   localparam logic [1:0] BASE_C = 2'b01;

   // Array scores are biased so that a zero score sits at mid-range.
   localparam logic [DEF_SCORE_WIDTH-1:0] ZERO = {1'b1, {(DEF_SCORE_WIDTH-1){1'b0}}};

   // Result error codes.
   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_TIMEOUT = 2'b01,
      ERR_BUBBLE  = 2'b10
   } err_e;

   // Job sequencer states.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_LOAD_Q = 3'd2,
      S_STREAM = 3'd3,
      S_DRAIN  = 3'd4,
      S_RESULT = 3'd5
   } state_e;

   // Bit count of a value: floor(log2(value)) + 1, so 128 -> 8.
   function automatic int log2b(input int value);
      int bits;
      bits = 0;
      for (int v = value; v > 0; v = v >> 1) begin
         bits++;
      end
      return bits;
   endfunction

endpackage

// File: rtl/sw_score_controller_if.sv
// Bundle of the host streams, result port and scoring-array connections
// seen by the job controller. The controller uses the master view; the
// environment (host, DMA and array) uses the slave view.
interface sw_score_controller_if
   import sw_score_controller_pkg::*;
#(
   parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
   parameter int LENGTH      = DEF_LENGTH,
   parameter int TGT_WIDTH   = DEF_TGT_WIDTH,
   parameter int LOG_LENGTH  = log2b(LENGTH)
) ();

   // Job request
   logic                    start_i;
   logic [LOG_LENGTH-1:0]   q_len_i;
   logic [TGT_WIDTH-1:0]    t_len_i;

   // Query base stream
   logic [1:0]              q_base_i;
   logic                    q_valid_i;
   logic                    q_ready_o;

   // Target base stream
   logic [1:0]              t_base_i;
   logic                    t_valid_i;
   logic                    t_ready_o;

   // Scoring array
   logic                    arr_rst_o;
   logic                    arr_en_o;
   logic [1:0]              arr_data_o;
   logic [2*LENGTH-1:0]     arr_query_o;
   logic [LOG_LENGTH-1:0]   arr_sel_o;
   logic                    arr_vld_i;
   logic [SCORE_WIDTH-1:0]  arr_score_i;

   // Result port and status
   logic [SCORE_WIDTH-1:0]  res_score_o;
   logic [1:0]              res_err_o;
   logic                    res_valid_o;
   logic                    res_ready_i;
   logic                    busy_o;

   modport master (
      input  start_i, q_len_i, t_len_i,
      input  q_base_i, q_valid_i,
      input  t_base_i, t_valid_i,
      input  arr_vld_i, arr_score_i,
      input  res_ready_i,
      output q_ready_o, t_ready_o,
      output arr_rst_o, arr_en_o, arr_data_o, arr_query_o, arr_sel_o,
      output res_score_o, res_err_o, res_valid_o, busy_o
   );

   modport slave (
      output start_i, q_len_i, t_len_i,
      output q_base_i, q_valid_i,
      output t_base_i, t_valid_i,
      output arr_vld_i, arr_score_i,
      output res_ready_i,
      input  q_ready_o, t_ready_o,
      input  arr_rst_o, arr_en_o, arr_data_o, arr_query_o, arr_sel_o,
      input  res_score_o, res_err_o, res_valid_o, busy_o
   );

endinterface

// File: rtl/sw_score_controller_query_loader.sv
// Query slot register for the scoring array. Bases arrive one per write
// strobe and land in consecutive 2-bit slots (slot k at bits [2k+1:2k]).
// A clear empties the register and rewinds the slot counter; writes beyond
// the captured query length are ignored, so the counter never wraps.
module sw_score_controller_query_loader
   import sw_score_controller_pkg::*;
#(
   parameter int LENGTH     = DEF_LENGTH,
   parameter int LOG_LENGTH = log2b(LENGTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [1:0]            base,
   input  logic [LOG_LENGTH-1:0] q_len,
   output logic [2*LENGTH-1:0]   query,
   output logic                  done
);

   logic [LOG_LENGTH-1:0] qcnt;
   logic                  do_write;

   // A write only lands while slots of the current query remain open.
   assign do_write = wr_en && (qcnt < q_len);
   // High on the write that fills the final slot of the query.
   assign done     = do_write && (qcnt == q_len - 1'b1);

   // Slot register and fill counter.
   always_ff @(posedge clk) begin
      // NOTE: the slot register is reset (not just the counter) so an
      // aborted job can never leak a partially loaded query into the next.
      if (!rst) begin
         query <= '0;
         qcnt  <= '0;
      end else if (clear) begin
         query <= '0;
         qcnt  <= '0;
      end else if (do_write) begin
         for (int k = 0; k < LENGTH; k++) begin
            if (qcnt == LOG_LENGTH'(k)) begin
               query[2*k +: 2] <= base;
            end
         end
         // do_write guarantees qcnt < q_len <= LENGTH, so this saturates at q_len.
         qcnt <= qcnt + 1'b1;
      end
   end

endmodule

// File: rtl/sw_score_controller.sv
// Job sequencer for one Smith-Waterman scoring array. Per job it clears the
// array, loads the query serially, streams the target into en/data, waits
// for the selected PE's vld and returns the score on a valid/ready port.
// One job is in flight at a time; every output is registered.
module sw_score_controller
   import sw_score_controller_pkg::*;
#(
   parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
   parameter int LENGTH      = DEF_LENGTH,
   parameter int LOG_LENGTH  = log2b(LENGTH),
   parameter int TGT_WIDTH   = DEF_TGT_WIDTH,
   parameter int TIMEOUT     = LENGTH + 8
) (
   input  logic                  clk,
   input  logic                  rst,
   sw_score_controller_if.master bus
);

   localparam int WAIT_WIDTH = $clog2(TIMEOUT + 1);
   localparam logic [SCORE_WIDTH-1:0] ZERO_SCORE = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

   state_e                state;
   logic [TGT_WIDTH-1:0]  t_len;
   logic [TGT_WIDTH-1:0]  tcnt;
   logic [WAIT_WIDTH-1:0] wcnt;

   logic start_ok;
   logic q_hs;
   logic t_hs;
   logic q_done;

   // A job request is only legal with a query that fits the array and a non-empty target.
   assign start_ok = (bus.q_len_i != '0) && (bus.q_len_i <= LOG_LENGTH'(LENGTH)) &&
                     (bus.t_len_i != '0);
   assign q_hs     = bus.q_valid_i && bus.q_ready_o;
   assign t_hs     = bus.t_valid_i && bus.t_ready_o;

   // arr_sel_o doubles as the captured query length for the loader.
   sw_score_controller_query_loader #(
      .LENGTH     (LENGTH),
      .LOG_LENGTH (LOG_LENGTH)
   ) u_loader (
      .clk   (clk),
      .rst   (rst),
      .clear (state == S_CLEAR),
      .wr_en (q_hs),
      .base  (bus.q_base_i),
      .q_len (bus.arr_sel_o),
      .query (bus.arr_query_o),
      .done  (q_done)
   );

   // Job FSM: each transition also loads the registered outputs of the state being entered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= S_IDLE;
         t_len           <= '0;
         tcnt            <= '0;
         wcnt            <= '0;
         bus.arr_rst_o   <= 1'b0;
         bus.arr_en_o    <= 1'b0;
         bus.arr_data_o  <= 2'b00;
         bus.arr_sel_o   <= '0;
         bus.q_ready_o   <= 1'b0;
         bus.t_ready_o   <= 1'b0;
         bus.res_score_o <= '0;
         bus.res_err_o   <= ERR_OK;
         bus.res_valid_o <= 1'b0;
         bus.busy_o      <= 1'b0;
      end else begin
         // NOTE: non-blocking default; a later assignment in this block wins,
         // so en is a one-cycle pulse per accepted target base.
         bus.arr_en_o <= 1'b0;

         case (state)
            S_IDLE: begin
               bus.arr_rst_o <= 1'b1;
               if (bus.start_i && start_ok) begin
                  bus.arr_sel_o <= bus.q_len_i;
                  t_len         <= bus.t_len_i;
                  bus.arr_rst_o <= 1'b0;
                  bus.busy_o    <= 1'b1;
                  state         <= S_CLEAR;
               end
            end

            S_CLEAR: begin
               tcnt          <= '0;
               wcnt          <= '0;
               bus.arr_rst_o <= 1'b1;
               bus.q_ready_o <= 1'b1;
               state         <= S_LOAD_Q;
            end

            S_LOAD_Q: begin
               if (q_done) begin
                  bus.q_ready_o <= 1'b0;
                  bus.t_ready_o <= 1'b1;
                  state         <= S_STREAM;
               end
            end

            S_STREAM: begin
               if (t_hs) begin
                  bus.arr_en_o   <= 1'b1;
                  bus.arr_data_o <= bus.t_base_i;
                  if (tcnt != '1) begin
                     tcnt <= tcnt + 1'b1;
                  end
                  if (tcnt == t_len - 1'b1) begin
                     bus.t_ready_o <= 1'b0;
                     wcnt          <= '0;
                     state         <= S_DRAIN;
                  end
               end else begin
                  // The array cannot stall: a missing target base ruins the alignment.
                  bus.t_ready_o   <= 1'b0;
                  bus.res_score_o <= ZERO_SCORE;
                  bus.res_err_o   <= ERR_BUBBLE;
                  bus.res_valid_o <= 1'b1;
                  state           <= S_RESULT;
               end
            end

            S_DRAIN: begin
               if (bus.arr_vld_i) begin
                  bus.res_score_o <= bus.arr_score_i;
                  bus.res_err_o   <= ERR_OK;
                  bus.res_valid_o <= 1'b1;
                  state           <= S_RESULT;
               end else if (wcnt == WAIT_WIDTH'(TIMEOUT - 1)) begin
                  bus.res_score_o <= ZERO_SCORE;
                  bus.res_err_o   <= ERR_TIMEOUT;
                  bus.res_valid_o <= 1'b1;
                  state           <= S_RESULT;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end

            S_RESULT: begin
               // Score and error hold until the consumer takes them; start is ignored here.
               if (bus.res_ready_i) begin
                  bus.res_valid_o <= 1'b0;
                  bus.busy_o      <= 1'b0;
                  state           <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sw_score_controller.sv
// Self-checking bench for sw_score_controller: a behavioural scoring-array
// model answers on the array side, a job table drives complete jobs with a
// scoreboard of expected results, and short hand-written sequences cover
// illegal starts and a reset in the middle of a stream.
module tb_sw_score_controller;
   import sw_score_controller_pkg::*;

   localparam int SW  = 12;
   localparam int LEN = 128;
   localparam int TW  = 16;
   localparam int LL  = log2b(LEN);
   localparam int TMO = LEN + 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sw_score_controller_if #(.SCORE_WIDTH(SW), .LENGTH(LEN), .TGT_WIDTH(TW)) bus ();

   sw_score_controller #(
      .SCORE_WIDTH (SW),
      .LENGTH      (LEN),
      .TGT_WIDTH   (TW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [2*LEN-1:0] act, input logic [2*LEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference local alignment: match +2, mismatch -1, gap -1, floor at 0.
   function automatic int sw_calc(input logic [1:0] q[$], input logic [1:0] t[$]);
      int h_prev [0:LEN];
      int h_cur  [0:LEN];
      int best;
      int v;
      best = 0;
      for (int i = 0; i <= LEN; i++) h_prev[i] = 0;
      foreach (t[j]) begin
         h_cur[0] = 0;
         for (int i = 1; i <= q.size(); i++) begin
            v = h_prev[i-1] + ((q[i-1] == t[j]) ? 2 : -1);
            if (h_prev[i] - 1 > v) v = h_prev[i] - 1;
            if (h_cur[i-1] - 1 > v) v = h_cur[i-1] - 1;
            if (v < 0) v = 0;
            h_cur[i] = v;
            if (v > best) best = v;
         end
         for (int i = 0; i <= LEN; i++) h_prev[i] = h_cur[i];
      end
      return best;
   endfunction

   function automatic logic [1:0] enc(input byte c);
      case (c)
         "A":     return BASE_A;
         "G":     return BASE_G;
         "T":     return BASE_T;
         default: return BASE_C;
      endcase
   endfunction

   // ---------------- scoring array model and monitors ----------------
   bit          mdl_respond = 1'b1;
   logic [1:0]  mdl_t[$];
   logic [1:0]  mdl_q[$];
   int          mdl_drain = 0;
   int          en_total = 0;
   int          drain_total = 0;

   function automatic bit in_drain();
      return bus.busy_o && bus.arr_rst_o && !bus.q_ready_o && !bus.t_ready_o && !bus.res_valid_o;
   endfunction

   // Array model: collects streamed bases and answers a few cycles into DRAIN.
   always @(negedge clk) begin
      if (bus.arr_en_o) en_total++;
      if (in_drain()) drain_total++;
      if (!bus.arr_rst_o) begin
         mdl_t.delete();
         mdl_drain       = 0;
         bus.arr_vld_i   = 1'b0;
         bus.arr_score_i = '0;
      end else begin
         if (bus.arr_en_o) mdl_t.push_back(bus.arr_data_o);
         if (in_drain()) begin
            mdl_drain++;
            if (mdl_respond && mdl_drain == 3) begin
               mdl_q.delete();
               for (int k = 0; k < int'(bus.arr_sel_o); k++) mdl_q.push_back(bus.arr_query_o[2*k +: 2]);
               bus.arr_score_i = ZERO + SW'(sw_calc(mdl_q, mdl_t));
               bus.arr_vld_i   = 1'b1;
            end
         end else begin
            mdl_drain     = 0;
            bus.arr_vld_i = 1'b0;
         end
      end
   end

   // ---------------- job table and scoreboard ----------------
   typedef struct {
      string      name;
      int         q_len;
      int         t_len;
      int         bubble_at;
      bit         respond;
      bit         q_gaps;
      int         ready_delay;
      string      q_str;
      string      t_str;
      logic [1:0] exp_err;
      int         exp_drain;
   } job_t;

   typedef struct {
      logic [1:0]    err;
      logic [SW-1:0] score;
   } exp_t;

   exp_t sb[$];

   function automatic job_t mk_job(input string name, input int q_len, input int t_len,
                                   input int bubble_at, input bit respond, input bit q_gaps,
                                   input int ready_delay, input string q_str, input string t_str,
                                   input logic [1:0] exp_err, input int exp_drain);
      job_t j;
      j.name = name; j.q_len = q_len; j.t_len = t_len; j.bubble_at = bubble_at;
      j.respond = respond; j.q_gaps = q_gaps; j.ready_delay = ready_delay;
      j.q_str = q_str; j.t_str = t_str; j.exp_err = exp_err; j.exp_drain = exp_drain;
      return j;
   endfunction

   // Starts at a negedge; returns at the negedge after the last accepted base.
   task automatic drive_query(input logic [1:0] q[$], input bit gaps, output int qi);
      int cyc;
      cyc = 0;
      qi  = 0;
      while (qi < q.size() && cyc < 8*LEN) begin
         bus.q_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.q_base_i  = q[qi];
         if (bus.q_valid_i && bus.q_ready_o) qi++;
         cyc++;
         @(negedge clk);
      end
      bus.q_valid_i = 1'b0;
   endtask

   task automatic drive_target(input logic [1:0] t[$], input int n, input bit keep_valid, output int ti);
      int cyc;
      cyc = 0;
      ti  = 0;
      while (ti < n && cyc < 4*n + 20) begin
         bus.t_valid_i = 1'b1;
         bus.t_base_i  = t[ti];
         if (bus.t_ready_o) ti++;
         cyc++;
         @(negedge clk);
      end
      if (!keep_valid) bus.t_valid_i = 1'b0;
   endtask

   task automatic run_job(input job_t j);
      logic [1:0]       q[$];
      logic [1:0]       t[$];
      logic [2*LEN-1:0] qpacked;
      int               n_stream, en0, dr0, qi, ti, cyc;
      exp_t             e;
      logic [SW-1:0]    s0;
      logic [1:0]       e0;
      bit               stable;

      qpacked = '0;
      for (int i = 0; i < j.q_len; i++) begin
         q.push_back(j.q_str.len() > 0 ? enc(j.q_str[i]) : 2'($urandom_range(0, 3)));
         qpacked[2*i +: 2] = q[i];
      end
      for (int i = 0; i < j.t_len; i++) begin
         t.push_back(j.t_str.len() > 0 ? enc(j.t_str[i]) : 2'($urandom_range(0, 3)));
      end
      n_stream = (j.bubble_at >= 0) ? j.bubble_at : j.t_len;

      e.err   = j.exp_err;
      e.score = (j.exp_err == ERR_OK) ? ZERO + SW'(sw_calc(q, t)) : ZERO;
      sb.push_back(e);
      mdl_respond = j.respond;
      en0 = en_total;
      dr0 = drain_total;

      @(negedge clk);
      bus.start_i = 1'b1;
      bus.q_len_i = LL'(j.q_len);
      bus.t_len_i = TW'(j.t_len);
      @(negedge clk);
      bus.start_i = 1'b0;
      check({j.name, ":busy_after_start"}, bus.busy_o, 1);
      check({j.name, ":arr_rst_in_clear"}, bus.arr_rst_o, 0);

      drive_query(q, j.q_gaps, qi);
      check({j.name, ":q_handshakes"}, qi, j.q_len);
      check({j.name, ":q_ready_drop"}, bus.q_ready_o, 0);
      check({j.name, ":t_ready_rise"}, bus.t_ready_o, 1);
      check({j.name, ":arr_query"}, bus.arr_query_o, qpacked);
      check({j.name, ":arr_sel"}, bus.arr_sel_o, j.q_len);

      drive_target(t, n_stream, 1'b0, ti);
      check({j.name, ":t_handshakes"}, ti, n_stream);

      cyc = 0;
      while (!bus.res_valid_o && cyc < TMO + 100) begin
         @(negedge clk);
         cyc++;
      end
      check({j.name, ":res_valid"}, bus.res_valid_o, 1);
      e = sb.pop_front();
      check({j.name, ":en_cycles"}, en_total - en0, n_stream);
      if (j.exp_drain >= 0) check({j.name, ":drain_cycles"}, drain_total - dr0, j.exp_drain);
      check({j.name, ":res_err"}, bus.res_err_o, e.err);
      if (e.err != ERR_BUBBLE) check({j.name, ":res_score"}, bus.res_score_o, e.score);

      s0 = bus.res_score_o;
      e0 = bus.res_err_o;
      stable = 1'b1;
      repeat (j.ready_delay) begin
         @(negedge clk);
         if (bus.res_score_o !== s0 || bus.res_err_o !== e0 || bus.res_valid_o !== 1'b1) stable = 1'b0;
      end
      check({j.name, ":res_stable"}, stable, 1);

      // A start in the result hand-off cycle must not launch a job.
      bus.res_ready_i = 1'b1;
      bus.start_i     = 1'b1;
      @(negedge clk);
      bus.res_ready_i = 1'b0;
      bus.start_i     = 1'b0;
      check({j.name, ":idle_after_ready"}, bus.busy_o, 0);
      check({j.name, ":res_valid_drop"}, bus.res_valid_o, 0);
   endtask

   task automatic bad_start(input string name, input int q_len, input int t_len);
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.q_len_i = LL'(q_len);
      bus.t_len_i = TW'(t_len);
      @(negedge clk);
      bus.start_i = 1'b0;
      check({name, ":busy"}, bus.busy_o, 0);
      check({name, ":no_arr_rst_pulse"}, bus.arr_rst_o, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      job_t       jobs[6];
      logic [1:0] rq[$];
      logic [1:0] rt[$];
      int         n;

      jobs[0] = mk_job("acgt",     4,   4,   -1, 1'b1, 1'b0, 0,  "ACGT", "ACGT", ERR_OK,      -1);
      jobs[1] = mk_job("full_len", 128, 300, -1, 1'b1, 1'b1, 10, "",     "",     ERR_OK,      -1);
      jobs[2] = mk_job("bubble",   5,   5,   2,  1'b1, 1'b0, 2,  "",     "",     ERR_BUBBLE,  0);
      jobs[3] = mk_job("timeout",  3,   6,   -1, 1'b0, 1'b0, 1,  "",     "",     ERR_TIMEOUT, TMO);
      jobs[4] = mk_job("single",   1,   1,   -1, 1'b1, 1'b0, 0,  "G",    "G",    ERR_OK,      -1);
      jobs[5] = mk_job("gappy",    10,  20,  -1, 1'b1, 1'b1, 3,  "",     "",     ERR_OK,      -1);

      bus.start_i = 1'b0; bus.q_len_i = '0; bus.t_len_i = '0;
      bus.q_base_i = '0; bus.q_valid_i = 1'b0;
      bus.t_base_i = '0; bus.t_valid_i = 1'b0;
      bus.res_ready_i = 1'b0;

      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset:busy", bus.busy_o, 0);
      check("reset:arr_rst", bus.arr_rst_o, 0);
      check("reset:q_ready", bus.q_ready_o, 0);
      check("reset:res_valid", bus.res_valid_o, 0);
      check("reset:arr_query", bus.arr_query_o, 0);
      rst = 1'b1;
      @(negedge clk);
      check("idle:arr_rst", bus.arr_rst_o, 1);

      for (int i = 0; i < 6; i++) run_job(jobs[i]);

      bad_start("qlen0", 0, 5);
      bad_start("qlen129", 129, 5);
      bad_start("tlen0", 4, 0);

      // Reset in the middle of a target stream.
      rq = '{BASE_G, BASE_G, BASE_G, BASE_G};
      rt = '{BASE_A, BASE_A, BASE_A, BASE_A, BASE_A, BASE_A};
      @(negedge clk);
      bus.start_i = 1'b1; bus.q_len_i = LL'(4); bus.t_len_i = TW'(6);
      @(negedge clk);
      bus.start_i = 1'b0;
      drive_query(rq, 1'b0, n);
      drive_target(rt, 3, 1'b1, n);
      check("midrst:pre_data", bus.arr_data_o, BASE_A);
      rst = 1'b0;
      @(negedge clk);
      check("midrst:busy", bus.busy_o, 0);
      check("midrst:arr_rst", bus.arr_rst_o, 0);
      check("midrst:arr_en", bus.arr_en_o, 0);
      check("midrst:arr_data", bus.arr_data_o, 0);
      check("midrst:arr_query", bus.arr_query_o, 0);
      check("midrst:arr_sel", bus.arr_sel_o, 0);
      check("midrst:t_ready", bus.t_ready_o, 0);
      check("midrst:res", {bus.res_score_o, bus.res_err_o, bus.res_valid_o}, 0);
      rst = 1'b1;
      bus.t_valid_i = 1'b0;
      @(negedge clk);
      check("midrst:idle_arr_rst", bus.arr_rst_o, 1);

      run_job(jobs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
